// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction classes,
// opcodes and the ALUSel/ImmSel/MemRW datapath select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    OP_BAD,
    OP_R,
    OP_I,
    OP_LOAD,
    OP_STORE,
    OP_LUI
  } op_class_t;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_U = 2'b10;

  localparam logic [1:0] MEMRW_IDLE = 2'b00;
  localparam logic [1:0] MEMRW_RD   = 2'b10;
  localparam logic [1:0] MEMRW_WR   = 2'b01;

  // Per-class datapath selects that stay fixed for the life of one instruction
  typedef struct packed {
    logic [1:0] imm_sel;
    logic       bsel;
    logic       wbsel;
    logic       auipc_sel;
  } sel_t;

  function automatic op_class_t op_class(input logic [6:0] opc);
    case (opc)
      OPC_R:     return OP_R;
      OPC_I:     return OP_I;
      OPC_LOAD:  return OP_LOAD;
      OPC_STORE: return OP_STORE;
      OPC_LUI:   return OP_LUI;
      default:   return OP_BAD;
    endcase
  endfunction

  function automatic sel_t sel_of(input op_class_t c);
    sel_t s;
    s = '0;
    case (c)
      OP_R:     begin s.imm_sel = IMM_I; s.bsel = 1'b0; s.wbsel = 1'b1; end
      OP_I:     begin s.imm_sel = IMM_I; s.bsel = 1'b1; s.wbsel = 1'b1; end
      OP_LOAD:  begin s.imm_sel = IMM_I; s.bsel = 1'b1; s.wbsel = 1'b0; end
      OP_STORE: begin s.imm_sel = IMM_S; s.bsel = 1'b1; s.wbsel = 1'b1; end
      OP_LUI:   begin s.imm_sel = IMM_U; s.bsel = 1'b1; s.wbsel = 1'b1; s.auipc_sel = 1'b1; end
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 to an ALU operation and flags unsupported encodings (SLTU, SRA/SRAI, bad funct).
// Purely combinational, zero latency; no handshake.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_t  cls,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_sel,
  output logic       legal
);

  logic f7_zero;
  logic f7_alt;
  logic base_ok;

  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  // funct7 is immediate bits for non-shift I-type, so only R-type constrains it there
  assign base_ok = (cls == OP_I) || f7_zero;

  always_comb begin
    alu_sel = ALU_ADD;
    legal   = 1'b0;
    case (cls)
      OP_R, OP_I: begin
        case (funct3)
          3'b000: begin
            alu_sel = (cls == OP_R && f7_alt) ? ALU_SUB : ALU_ADD;
            legal   = base_ok || (cls == OP_R && f7_alt);
          end
          3'b001: begin alu_sel = ALU_SLL; legal = f7_zero; end
          3'b010: begin alu_sel = ALU_SLT; legal = base_ok; end
          3'b100: begin alu_sel = ALU_XOR; legal = base_ok; end
          3'b101: begin alu_sel = ALU_SRL; legal = f7_zero; end
          3'b110: begin alu_sel = ALU_OR;  legal = base_ok; end
          3'b111: begin alu_sel = ALU_AND; legal = base_ok; end
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
      OP_LUI:            legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB, sticky TRAP); one state per cycle, MEM stalls on mem_ready.
// MULTICYCLE_CTRL_TIMEOUT_EN bounds the MEM stall to MEM_WAIT_MAX waiting cycles before trapping.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWEn,
  output logic        Bsel,
  output logic        WBSel,
  output logic        AuipcSel,
  output logic        illegal,
  output logic [1:0]  ImmSel,
  output logic [2:0]  ALUSel,
  output logic [1:0]  MemRW
);

  state_t     state;
  op_class_t  cls_live;
  op_class_t  cls_q;
  sel_t       sel_live;
  sel_t       sel_q;
  logic [2:0] alu_live;
  logic [2:0] alu_q;
  logic       dec_legal;
  logic       pc_write_q;
  logic       ir_write_q;
  logic       reg_wen_q;
  logic       illegal_q;
  logic [1:0] mem_rw_q;
  logic       mem_timeout;
  logic       store_done;
  logic       unused_inst;

  assign cls_live    = op_class(inst[6:0]);
  assign sel_live    = sel_of(cls_live);
  assign unused_inst = ^{inst[24:15], inst[11:7]};

  alu_decoder u_alu_decoder (
    .cls     (cls_live),
    .funct3  (inst[14:12]),
    .funct7  (inst[31:25]),
    .alu_sel (alu_live),
    .legal   (dec_legal)
  );

  // A store retires in the cycle the memory accepts it, so PCWrite follows mem_ready directly
  assign store_done = (state == S_MEM) && (cls_q == OP_STORE) && mem_ready;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != S_MEM) begin
      wait_cnt <= '0;
    end else if (!mem_ready && !mem_timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign mem_timeout = !mem_ready && (wait_cnt == WAIT_LIMIT);
`else
  localparam int unused_wait_max = MEM_WAIT_MAX;
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cls_q      <= OP_BAD;
      sel_q      <= '0;
      alu_q      <= ALU_ADD;
      pc_write_q <= 1'b0;
      ir_write_q <= 1'b0;
      reg_wen_q  <= 1'b0;
      mem_rw_q   <= MEMRW_IDLE;
      illegal_q  <= 1'b0;
    end else begin
      pc_write_q <= 1'b0;
      ir_write_q <= 1'b0;
      reg_wen_q  <= 1'b0;
      mem_rw_q   <= MEMRW_IDLE;
      case (state)
        S_IDLE: begin
          state      <= S_FETCH;
          ir_write_q <= 1'b1;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (dec_legal) begin
            state <= S_EXEC;
            cls_q <= cls_live;
            sel_q <= sel_live;
            alu_q <= alu_live;
          end else begin
            state     <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (cls_q == OP_LOAD || cls_q == OP_STORE) begin
            state    <= S_MEM;
            mem_rw_q <= (cls_q == OP_LOAD) ? MEMRW_RD : MEMRW_WR;
          end else begin
            state      <= S_WB;
            pc_write_q <= 1'b1;
            reg_wen_q  <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (cls_q == OP_LOAD) begin
              state      <= S_WB;
              pc_write_q <= 1'b1;
              reg_wen_q  <= 1'b1;
            end else begin
              state      <= S_FETCH;
              ir_write_q <= 1'b1;
              cls_q      <= OP_BAD;
              sel_q      <= '0;
              alu_q      <= ALU_ADD;
            end
          end else if (mem_timeout) begin
            state     <= S_TRAP;
            illegal_q <= 1'b1;
            cls_q     <= OP_BAD;
            sel_q     <= '0;
            alu_q     <= ALU_ADD;
          end else begin
            mem_rw_q <= mem_rw_q;
          end
        end
        S_WB: begin
          state      <= S_FETCH;
          ir_write_q <= 1'b1;
          cls_q      <= OP_BAD;
          sel_q      <= '0;
          alu_q      <= ALU_ADD;
        end
        S_TRAP: state <= S_TRAP;
        default: begin
          state     <= S_TRAP;
          illegal_q <= 1'b1;
          cls_q     <= OP_BAD;
          sel_q     <= '0;
          alu_q     <= ALU_ADD;
        end
      endcase
    end
  end

  assign PCWrite = pc_write_q | store_done;
  assign IRWrite = ir_write_q;
  assign RegWEn  = reg_wen_q;
  assign MemRW   = mem_rw_q;
  assign illegal = illegal_q;

  // DECODE drives the live decode so selects are valid as soon as IR is; held copies cover EXEC..WB
  always_comb begin
    ImmSel   = sel_q.imm_sel;
    Bsel     = sel_q.bsel;
    WBSel    = sel_q.wbsel;
    AuipcSel = sel_q.auipc_sel;
    ALUSel   = alu_q;
    if (state == S_DECODE && dec_legal) begin
      ImmSel   = sel_live.imm_sel;
      Bsel     = sel_live.bsel;
      WBSel    = sel_live.wbsel;
      AuipcSel = sel_live.auipc_sel;
      ALUSel   = alu_live;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, giving the maximum MEM-state cycles without mem_ready before a trap.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port inst, input, 32, the instruction word held in the datapath IR.
REQ-005 SHALL have port mem_ready, input, 1, the DMEM completion handshake.
REQ-006 SHALL have ports PCWrite, IRWrite, RegWEn, Bsel, WBSel, AuipcSel, illegal, each output, 1.
REQ-007 SHALL have ports ImmSel (2), ALUSel (3) and MemRW (2) as outputs.

Function
REQ-008 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-009 SHALL transition IDLE->FETCH->DECODE unconditionally, one cycle each.
REQ-010 SHALL assert IRWrite only in FETCH.
REQ-011 SHALL decode inst in DECODE: R 0110011, I-ALU 0010011, LOAD 0000011 (funct3 010), STORE 0100011 (funct3 010), LUI 0110111; any other opcode or funct goes to TRAP.
REQ-012 SHALL go EXEC->WB for R, I-ALU and LUI; EXEC->MEM for LOAD and STORE.
REQ-013 SHALL hold MemRW=10 (LOAD) or 01 (STORE) for every MEM cycle; MemRW=00 in all other states.
REQ-014 SHALL, in MEM with mem_ready=1, go to WB for LOAD; for STORE it SHALL assert PCWrite in that cycle and go to FETCH.
REQ-015 SHALL assert RegWEn=1 and PCWrite=1 only in WB, then go to FETCH.
REQ-016 SHALL set WBSel=0 (memory data) for LOAD and 1 (ALU result) otherwise.
REQ-017 SHALL set Bsel=1 for I-ALU/LOAD/STORE/LUI and 0 for R.
REQ-018 SHALL set ImmSel to 00 for I/LOAD, 01 for STORE, 10 for LUI, and 00 for R.
REQ-019 SHALL set AuipcSel=1 only for LUI.
REQ-020 SHALL hold ImmSel/Bsel/AuipcSel/ALUSel stable from DECODE through WB.
REQ-021 SHALL set ALUSel: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT; LOAD/STORE/LUI use ADD.
REQ-022 SHALL select SUB only for R with funct7=0100000, funct3=000; SLTU, SRA and SRAI SHALL trap.
REQ-023 SHALL make TRAP sticky until reset, with illegal=1 and all enables and MemRW at 0.
REQ-024 SHALL give mem_ready=1 priority over timeout in the same cycle.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, the wait counter to 0 and every output to 0, asynchronously.
REQ-026 SHALL, on reset mid-MEM, drop MemRW to 0 immediately and discard the pending access.

Configuration
REQ-027 SHALL, with MULTICYCLE_CTRL_TIMEOUT_EN defined, clear the wait counter on MEM entry, increment it on each MEM cycle with mem_ready=0, and go to TRAP when counter==MEM_WAIT_MAX and mem_ready=0.
REQ-028 SHALL, without MULTICYCLE_CTRL_TIMEOUT_EN, contain no counter and wait in MEM indefinitely.

Structure
REQ-029 SHALL place the state enum, opcode constants, and ALUSel/ImmSel/MemRW codes in shared package ctrl_pkg.
REQ-030 SHALL put the funct3/funct7 to ALUSel mapping and funct legality in sub-module alu_decoder.

Verification
REQ-031 SHALL cover: reset, then inst=0x00500093 (addi x1,x0,5) -> IDLE,FETCH,DECODE,EXEC,WB; in WB RegWEn=1, PCWrite=1, Bsel=1, WBSel=1, ALUSel=000.
REQ-032 SHALL cover: inst=0x0000A103 (lw), mem_ready high on the 3rd MEM cycle -> MemRW=10 for exactly 3 cycles, then WB with WBSel=0, RegWEn=1.
REQ-033 SHALL cover: inst=0x0020A023 (sw), mem_ready=1 on the first MEM cycle -> MemRW=01 and PCWrite=1 in one cycle; RegWEn never 1.
REQ-034 SHALL cover: inst=0x123452B7 (lui x5) -> AuipcSel=1, ImmSel=10, Bsel=1, ALUSel=000, RegWEn=1 in WB.
REQ-035 SHALL cover: inst=0x00000000 -> TRAP after DECODE, illegal=1 held for 20 cycles, cleared only by rst=0.
REQ-036 SHALL cover: lw with mem_ready=0 and MEM_WAIT_MAX=15 -> with the macro, TRAP after 16 MEM cycles; without it, still in MEM after 100 cycles.
